// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start / data (LSB first) / optional even parity / stop
// serializer, each bit held for SAMPLES clocks.
module uart_tx #(
    parameter int WIDTH       = 8,
    parameter int PARITY      = 0,
    parameter int SAMPLES     = 16,
    parameter int BUF_ADDR_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     wrData,
    input  logic                 wrEn,
    output logic                 full,
    output logic [BUF_ADDR_SZ:0] count,
    output logic                 busy,
    output logic                 TxOut
);

    localparam int DEPTH = 1 << BUF_ADDR_SZ;
    localparam int CNT_W = $clog2(SAMPLES);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       sample_reg, sample_next;
    logic [IDX_W-1:0]       bit_reg, bit_next;
    logic [WIDTH-1:0]       shift_reg, shift_next;
    logic                   parity_reg, parity_next;
    logic                   tx_reg, tx_next;
    logic [BUF_ADDR_SZ-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [BUF_ADDR_SZ:0]   count_reg, count_next;
    logic                   full_reg;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic                   push;
    logic                   pop;
    logic                   bit_done;

    // full is the registered flag, so a pop on the same edge never frees room for a write
    assign push     = wrEn && !full_reg;
    assign bit_done = (sample_reg == CNT_W'(SAMPLES - 1));

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage array and its registered read port; the shift register is the read data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wrData;
        end
        if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
        end else begin
            shift_reg <= shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            sample_reg <= '0;
            bit_reg    <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sample_reg <= sample_next;
            bit_reg    <= bit_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg  <= count_next;
            full_reg   <= (count_next == (BUF_ADDR_SZ + 1)'(DEPTH));
        end
    end

    always_comb begin
        state_next  = state_reg;
        sample_next = sample_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        tx_next     = tx_reg;
        pop         = 1'b0;

        // SAMPLES is a power of two, so the free-running increment wraps at each bit boundary
        if (state_reg != IDLE) begin
            sample_next = sample_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                tx_next     = 1'b1;
                sample_next = '0;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next  = DATA;
                    bit_next    = '0;
                    tx_next     = shift_reg[0];
                    // shift register still holds the untouched byte here
                    parity_next = ^shift_reg;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_reg == IDX_W'(WIDTH - 1)) begin
                        if (PARITY != 0) begin
                            state_next = PAR;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_reg + IDX_W'(1);
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_next[0];
                    end
                end
            end
            PAR: begin
                if (bit_done) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign full  = full_reg;
    assign count = count_reg;
    assign busy  = (state_reg != IDLE);
    assign TxOut = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one instance without parity, one with even parity;
// the serial waveform is compared clock by clock against frames built from the byte values.
module tb_uart_tx;

    localparam int W = 8;
    localparam int S = 16;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] wr_data0 = '0, wr_data1 = '0;
    logic         wr_en0 = 1'b0, wr_en1 = 1'b0;
    logic         full0, full1, busy0, busy1, tx0, tx1;
    logic [A:0]   count0, count1;

    int           n_checks = 0;
    int           n_fail = 0;
    int           n_print = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(W), .PARITY(0), .SAMPLES(S), .BUF_ADDR_SZ(A)) dut0 (
        .clk(clk), .rst(rst), .wrData(wr_data0), .wrEn(wr_en0),
        .full(full0), .count(count0), .busy(busy0), .TxOut(tx0)
    );

    uart_tx #(.WIDTH(W), .PARITY(1), .SAMPLES(S), .BUF_ADDR_SZ(A)) dut1 (
        .clk(clk), .rst(rst), .wrData(wr_data1), .wrEn(wr_en1),
        .full(full1), .count(count1), .busy(busy1), .TxOut(tx1)
    );

    // Drive one write on the next rising edge; call while aligned to a falling edge.
    task automatic write_byte(input bit sel, input logic [W-1:0] b);
        if (sel) begin
            wr_data1 = b;
            wr_en1   = 1'b1;
        end else begin
            wr_data0 = b;
            wr_en0   = 1'b1;
        end
        @(negedge clk);
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        wr_data0 = 8'($urandom);
        wr_data1 = 8'($urandom);
    endtask

    // Frames expected on the line: start 0, data LSB first, even parity (sel=1), stop 1.
    task automatic check_frames(input bit sel, input string tag);
        int           bits[$];
        logic [W-1:0] b;
        logic         got, bz;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            bits = {};
            bits.push_back(0);
            for (int i = 0; i < W; i++) bits.push_back((int'(b) >> i) & 1);
            if (sel) bits.push_back($countones(b) % 2);
            bits.push_back(1);
            for (int i = 0; i < bits.size(); i++) begin
                for (int s = 0; s < S; s++) begin
                    @(negedge clk);
                    got = sel ? tx1 : tx0;
                    bz  = sel ? busy1 : busy0;
                    n_checks++;
                    if (got !== 1'(bits[i]) || bz !== 1'b1) begin
                        n_fail++;
                        if (n_print < 20)
                            $display("FAIL %s byte %02h bit %0d clk %0d: TxOut=%b busy=%b, expected TxOut=%0d busy=1",
                                     tag, b, i, s, got, bz, bits[i]);
                        n_print++;
                    end
                end
            end
            $display("%s: frame %02h (%0d clocks) compared", tag, b, bits.size() * S);
        end
        @(negedge clk);
        got = sel ? tx1 : tx0;
        bz  = sel ? busy1 : busy0;
        n_checks++;
        if (got !== 1'b1 || bz !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end-of-stream: TxOut=%b busy=%b, expected TxOut=1 busy=0", tag, got, bz);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            n_checks++;
            if ({tx0, busy0, count0, full0} !== {1'b1, 1'b0, 5'd0, 1'b0} ||
                {tx1, busy1, count1, full1} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle clk %0d: tx=%b/%b busy=%b/%b count=%0d/%0d full=%b/%b, expected tx=1 busy=0 count=0 full=0",
                         c, tx0, tx1, busy0, busy1, count0, count1, full0, full1);
            end
            @(negedge clk);
        end
        $display("reset: 100 idle clocks compared");
    endtask

    task automatic test_single();
        exp_q = {8'h55};
        fork
            begin
                write_byte(1'b0, 8'h55);
                n_checks++;
                if (count0 !== 5'd1) begin
                    n_fail++;
                    $display("FAIL single_count: count=%0d, expected 1", count0);
                end
            end
            begin
                @(negedge clk);
                check_frames(1'b0, "single");
            end
        join
    endtask

    task automatic test_parity();
        logic [W-1:0] vals[$];
        vals = {8'h07, 8'h03, 8'($urandom), 8'($urandom), 8'($urandom)};
        foreach (vals[i]) begin
            exp_q = {vals[i]};
            fork
                write_byte(1'b1, vals[i]);
                begin
                    @(negedge clk);
                    check_frames(1'b1, "parity");
                end
            join
        end
    endtask

    task automatic test_random_burst();
        logic [W-1:0] vals[$];
        for (int r = 0; r < 2; r++) begin
            vals = {};
            for (int i = 0; i < 3; i++) vals.push_back(8'($urandom));
            exp_q = vals;
            fork
                foreach (vals[i]) write_byte(1'b0, vals[i]);
                begin
                    @(negedge clk);
                    check_frames(1'b0, "burst");
                end
            join
        end
    endtask

    task automatic test_back_to_back();
        exp_q = {8'hA5, 8'h3C};
        fork
            begin
                write_byte(1'b0, 8'hA5);
                write_byte(1'b0, 8'h3C);
            end
            begin
                @(negedge clk);
                check_frames(1'b0, "back_to_back");
            end
        join
    endtask

    task automatic test_full();
        logic [W-1:0] vals[$];
        for (int i = 0; i < 18; i++) vals.push_back(8'($urandom));
        exp_q = vals[0:16];
        fork
            begin
                for (int j = 0; j < 18; j++) begin
                    write_byte(1'b0, vals[j]);
                    if (j == 1 || j == 15 || j == 16 || j == 17) begin
                        n_checks++;
                        if (count0 !== 5'(j > 16 ? 16 : j) || full0 !== (j >= 16)) begin
                            n_fail++;
                            $display("FAIL full_write%0d: count=%0d full=%b, expected count=%0d full=%0d",
                                     j, count0, full0, (j > 16 ? 16 : j), (j >= 16));
                        end
                    end
                end
            end
            begin
                @(negedge clk);
                check_frames(1'b0, "full");
            end
        join
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 5'd0) begin
                n_fail++;
                $display("FAIL full_after clk %0d: tx=%b busy=%b count=%0d, expected 1 0 0", c, tx0, busy0, count0);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] first;
        first = 8'($urandom) & 8'hF7;
        write_byte(1'b0, first);
        for (int i = 0; i < 5; i++) write_byte(1'b0, 8'($urandom));
        repeat (65) @(negedge clk);
        n_checks++;
        if (tx0 !== first[3] || busy0 !== 1'b1 || count0 !== 5'd5) begin
            n_fail++;
            $display("FAIL pre_reset: tx=%b busy=%b count=%0d, expected tx=%b busy=1 count=5", tx0, busy0, count0, first[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 5'd0 || full0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tx=%b busy=%b count=%0d full=%b, expected 1 0 0 0", tx0, busy0, count0, full0);
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset clk %0d: tx=%b busy=%b, expected 1 0", c, tx0, busy0);
            end
        end
        $display("reset mid-frame: line idle for 200 clocks afterwards");
    endtask

    task automatic test_recover();
        exp_q = {8'h5A};
        fork
            write_byte(1'b0, 8'h5A);
            begin
                @(negedge clk);
                check_frames(1'b0, "recover");
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_random_burst();
        test_back_to_back();
        test_full();
        test_reset_mid_frame();
        test_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
